// File: rtl/ps2_move_decoder.sv
// PS2 set-2 scan-code decoder producing WASD (and, with ARROW_KEYS_EN defined,
// arrow-key) movement press pulses and held levels with typematic suppression.
module ps2_move_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  CODE_UP        = 8'h1D,
  parameter logic [7:0]  CODE_DOWN      = 8'h1B,
  parameter logic [7:0]  CODE_LEFT      = 8'h1C,
  parameter logic [7:0]  CODE_RIGHT     = 8'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_valid,
  output logic [3:0] key_pressed,
  output logic [3:0] key_held,
  output logic       timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TCNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic          terr_n;
  logic          do_make, do_break, is_ext;
  logic [3:0]    held_main, held_main_n, held_ext, held_ext_n;
  logic [3:0]    press_main, press_ext, dir_main;

  function automatic logic [3:0] map_main(input logic [7:0] code);
    if (code == CODE_UP)         return 4'b0001;
    else if (code == CODE_DOWN)  return 4'b0010;
    else if (code == CODE_LEFT)  return 4'b0100;
    else if (code == CODE_RIGHT) return 4'b1000;
    else                         return 4'b0000;
  endfunction

  always_comb begin
    state_n  = state;
    tcnt_n   = tcnt;
    terr_n   = 1'b0;
    do_make  = 1'b0;
    do_break = 1'b0;
    is_ext   = 1'b0;
    if (ps2_valid) begin
      tcnt_n = '0;
      case (state)
        IDLE: begin
          if (ps2_byte == 8'hE0)      state_n = EXT;
          else if (ps2_byte == 8'hF0) state_n = BRK;
          else if (ps2_byte != 8'hFA && ps2_byte != 8'hAA && ps2_byte != 8'hEE &&
                   ps2_byte != 8'hFE && ps2_byte != 8'hE1)
            do_make = 1'b1;
        end
        EXT: begin
          if (ps2_byte == 8'hF0)      state_n = EXT_BRK;
          else if (ps2_byte != 8'hE0) begin
            do_make = 1'b1;
            is_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          if (ps2_byte == 8'hE0)      state_n = EXT;
          else if (ps2_byte != 8'hF0) begin
            do_break = 1'b1;
            state_n  = IDLE;
          end
        end
        default: begin
          do_break = 1'b1;
          is_ext   = 1'b1;
          state_n  = IDLE;
        end
      endcase
    end else if (state != IDLE) begin
      // A strobe in the terminal cycle takes the branch above, so it wins over the timeout
      if (tcnt == TCNT_LAST) begin
        state_n = IDLE;
        terr_n  = 1'b1;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end else begin
      tcnt_n = '0;
    end
  end

  always_comb begin
    dir_main    = map_main(ps2_byte);
    held_main_n = held_main;
    press_main  = '0;
    if (do_make && !is_ext) begin
      press_main  = dir_main & ~held_main;
      held_main_n = held_main | dir_main;
    end else if (do_break && !is_ext) begin
      held_main_n = held_main & ~dir_main;
    end
  end

`ifdef ARROW_KEYS_EN
  logic [3:0] dir_ext;

  always_comb begin
    case (ps2_byte)
      8'h75:   dir_ext = 4'b0001;
      8'h72:   dir_ext = 4'b0010;
      8'h6B:   dir_ext = 4'b0100;
      8'h74:   dir_ext = 4'b1000;
      default: dir_ext = 4'b0000;
    endcase
    held_ext_n = held_ext;
    press_ext  = '0;
    if (do_make && is_ext) begin
      press_ext  = dir_ext & ~held_ext;
      held_ext_n = held_ext | dir_ext;
    end else if (do_break && is_ext) begin
      held_ext_n = held_ext & ~dir_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) held_ext <= '0;
    else     held_ext <= held_ext_n;
  end
`else
  assign held_ext   = '0;
  assign held_ext_n = '0;
  assign press_ext  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      held_main   <= '0;
      key_pressed <= '0;
      key_held    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      held_main   <= held_main_n;
      key_pressed <= press_main | press_ext;
      key_held    <= held_main_n | held_ext_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed scoreboard bench for ps2_move_decoder; expectations honour ARROW_KEYS_EN.
module tb_ps2_move_decoder;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_byte = '0;
  logic       ps2_valid = 1'b0;
  logic [3:0] key_pressed, key_held;
  logic       timeout_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [8:0]  sb[$];

  ps2_move_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(CLOCK_50),
    .rst(rst),
    .ps2_byte(ps2_byte),
    .ps2_valid(ps2_valid),
    .key_pressed(key_pressed),
    .key_held(key_held),
    .timeout_err(timeout_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

`ifdef ARROW_KEYS_EN
  localparam bit ARROWS = 1'b1;
`else
  localparam bit ARROWS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed pressed/held/terr=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [8:0] exp;
    exp = sb.pop_front();
    chk(tag, {key_pressed, key_held, timeout_err}, exp);
  endtask

  // Strobe one byte; outputs for it are sampled #1 after the capturing edge.
  task automatic send(input string tag, input logic [7:0] b, input logic [3:0] ep, input logic [3:0] eh);
    @(negedge CLOCK_50);
    ps2_byte  = b;
    ps2_valid = 1'b1;
    sb.push_back({ep, eh, 1'b0});
    @(posedge CLOCK_50);
    #1;
    ps2_valid = 1'b0;
    pop_check(tag);
  endtask

  task automatic quiet(input string tag, input int unsigned n, input logic [3:0] eh);
    for (int unsigned i = 0; i < n; i++) begin
      sb.push_back({4'b0000, eh, 1'b0});
      @(posedge CLOCK_50);
      #1;
      pop_check(tag);
    end
  endtask

  initial begin
    int unsigned pulses;
    int unsigned first_at;

    repeat (2) @(posedge CLOCK_50);
    #1;
    sb.push_back(9'b0);
    pop_check("reset");
    @(negedge CLOCK_50);
    rst = 1'b0;

    // W press, then typematic repeats and release
    send("make_w", 8'h1D, 4'b0001, 4'b0001);
    quiet("w_hold", 3, 4'b0001);
    send("rep1", 8'h1D, 4'b0000, 4'b0001);
    send("rep2", 8'h1D, 4'b0000, 4'b0001);
    send("rep3", 8'h1D, 4'b0000, 4'b0001);
    send("brk_f0", 8'hF0, 4'b0000, 4'b0001);
    send("brk_w", 8'h1D, 4'b0000, 4'b0000);
    quiet("w_rel", 3, 4'b0000);

    // Arrow left plus A, released separately
    send("ext_e0", 8'hE0, 4'b0000, 4'b0000);
    send("ext_6b", 8'h6B, ARROWS ? 4'b0100 : 4'b0000, ARROWS ? 4'b0100 : 4'b0000);
    send("make_a", 8'h1C, 4'b0100, 4'b0100);
    send("eb_e0", 8'hE0, 4'b0000, 4'b0100);
    send("eb_f0", 8'hF0, 4'b0000, 4'b0100);
    send("eb_6b", 8'h6B, 4'b0000, 4'b0100);
    send("ba_f0", 8'hF0, 4'b0000, 4'b0100);
    send("ba_1c", 8'h1C, 4'b0000, 4'b0000);

    // Timeout after lone E0: counter ticks 0..15, fires on the 16th idle cycle
    send("to_e0", 8'hE0, 4'b0000, 4'b0000);
    pulses = 0;
    first_at = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(posedge CLOCK_50);
      #1;
      if (timeout_err === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
    chk("to_pulses", 9'(pulses), 9'd1);
    chk("to_cycle", 9'(first_at), 9'd16);
    send("to_make_d", 8'h23, 4'b1000, 4'b1000);
    send("d_f0", 8'hF0, 4'b0000, 4'b1000);
    send("d_brk", 8'h23, 4'b0000, 4'b0000);

    // A strobe in the terminal count cycle is processed, no timeout
    send("edge_e0", 8'hE0, 4'b0000, 4'b0000);
    quiet("edge_wait", 15, 4'b0000);
    send("edge_6b", 8'h6B, ARROWS ? 4'b0100 : 4'b0000, ARROWS ? 4'b0100 : 4'b0000);
    quiet("edge_after", 20, ARROWS ? 4'b0100 : 4'b0000);
    send("edge_c0", 8'hE0, 4'b0000, ARROWS ? 4'b0100 : 4'b0000);
    send("edge_c1", 8'hF0, 4'b0000, ARROWS ? 4'b0100 : 4'b0000);
    send("edge_c2", 8'h6B, 4'b0000, 4'b0000);

    // Reset mid-sequence discards the F0 prefix
    send("mid_f0", 8'hF0, 4'b0000, 4'b0000);
    @(negedge CLOCK_50);
    rst = 1'b1;
    sb.push_back(9'b0);
    @(posedge CLOCK_50);
    #1;
    pop_check("mid_rst");
    @(negedge CLOCK_50);
    rst = 1'b0;
    send("mid_1b", 8'h1B, 4'b0010, 4'b0010);
    send("s_f0", 8'hF0, 4'b0000, 4'b0010);
    send("s_brk", 8'h1B, 4'b0000, 4'b0000);

    // Ignored and unmapped bytes
    send("ign_fa", 8'hFA, 4'b0000, 4'b0000);
    send("ign_aa", 8'hAA, 4'b0000, 4'b0000);
    send("unm_5a", 8'h5A, 4'b0000, 4'b0000);
    send("unm_f0", 8'hF0, 4'b0000, 4'b0000);
    send("unm_brk", 8'h5A, 4'b0000, 4'b0000);
    quiet("final_quiet", 20, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Upstream of the player-position block.
- Turns the byte stream from the PS2 receiver (scan-code set 2) into per-direction movement pulses and held levels.
- Decodes make, break and extended (E0) sequences, and suppresses typematic auto-repeat so each physical key press yields exactly one single-cycle pulse.
- key_pressed feeds the player block's key_pressed input directly.

Parameters:
- TIMEOUT_CYCLES, 2500000: clocks allowed between prefix and final byte (50 ms at 50 MHz) before the sequence is abandoned.
- CODE_UP, 8'h1D: set-2 make code for W.
- CODE_DOWN, 8'h1B: make code for S.
- CODE_LEFT, 8'h1C: make code for A.
- CODE_RIGHT, 8'h23: make code for D.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous reset, active-high
- ps2_byte  in  8  received scan-code byte
- ps2_valid  in  1  one-cycle strobe; ps2_byte valid this cycle
- key_pressed  out  4  one-cycle press pulses; [0]=up, [1]=down, [2]=left, [3]=right
- key_held  out  4  level, same bit order; direction currently held by any source
- timeout_err  out  1  one-cycle pulse when a partial sequence is abandoned

Behaviour:
- Reset: rst sampled on posedge clk; rst has priority over ps2_valid. Reset clears:
  - FSM to IDLE
  - all held bits to 0
  - key_pressed = 0, key_held = 0, timeout_err = 0
  - timeout counter to 0
  Reset mid-sequence discards the partial sequence; no pulse results.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions on ps2_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; FA/AA/EE/FE/E1 -> ignored, stay IDLE; other -> make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> make(code, ext=1) -> IDLE.
  - BRK: F0 -> stay BRK; E0 -> EXT (malformed, restart); other -> break(code, ext=0) -> IDLE.
  - EXT_BRK: any byte -> break(code, ext=1) -> IDLE.
- Held state: two 4-bit registers, held_main (ext=0 codes) and held_ext (ext=1 codes).
  - key_held = held_main | held_ext, registered.
- make(code, ext), code mapped to direction d in the selected register:
  - Held bit was 0: set it, and assert key_pressed[d] for exactly one cycle, the cycle after the ps2_valid of the final byte (latency 1).
  - Held bit already 1 (typematic repeat): no pulse.
  - A press from the second source while the first is held still pulses, because that source's bit rose.
- break(code, ext), mapped: clear the held bit; no pulse.
- Unmapped codes: fully parsed, no output effect.
- Timeout counter:
  - Counts each cycle while state != IDLE and ps2_valid = 0; cleared on any ps2_valid and in IDLE.
  - When it reaches TIMEOUT_CYCLES-1: state -> IDLE, timeout_err = 1 for one cycle, counter -> 0.
  - A ps2_valid in that same cycle is processed normally and no timeout fires.
- key_pressed, key_held and timeout_err are all registered outputs. More than one key_pressed bit can assert only if both bytes complete in the same cycle, which is impossible, so at most one bit pulses per cycle.

Optional Feature:
- Macro ARROW_KEYS_EN.
  - Defined: ext=1 make/break codes map 75->up, 72->down, 6B->left, 74->right into held_ext.
  - Undefined: held_ext is tied to 0; E0 sequences are still parsed and consumed, with no effect on outputs.
- WASD mapping is always present.

Test Plan:
- rst=1 for 2 cycles, then single byte 1D -> key_pressed=4'b0001 for one cycle, one cycle after the strobe; key_held=4'b0001 thereafter.
- Bytes 1D,1D,1D (typematic), then F0,1D -> exactly one pulse on bit0; key_held returns to 0 one cycle after the 1D strobe that follows F0; no further pulses.
- With ARROW_KEYS_EN: E0,6B -> key_pressed=4'b0100 pulse. Then 1C -> second pulse on bit2. Then E0,F0,6B -> key_held stays 4'b0100 (A still held). Then F0,1C -> key_held=0. Without the macro, the E0,6B step produces no output.
- E0 alone, then no strobe for TIMEOUT_CYCLES (shortened to 16 in bench) -> timeout_err pulses once, FSM in IDLE. A following 23 then gives a key_pressed=4'b1000 pulse (treated as plain make, not ext).
- Send F0, assert rst for one cycle, then send 1B -> treated as make: key_pressed=4'b0010 pulse, key_held=4'b0010.
- Bytes FA, AA, 5A (unmapped), F0, 5A -> no pulses, key_held=0, no timeout_err.
